intr_ctrl: RTL
==============

// Module: intr_ctrl
// PURPOSE
//  Machine-level interrupt source block feeding the CSR/trap unit's i_ext_intr and i_sw_intr inputs.
//  - Synchronises the asynchronous external interrupt pin.
//  - Holds a memory-mapped software-interrupt bit (MSIP).
//  - Implements a 64-bit machine timer (mtime/mtimecmp) and raises a timer interrupt when it is due.
//  - All outputs are registered and level-style; they are held until the source is cleared.
// PARAMETERS
//  SYNC_STAGES  2  synchroniser flop count on i_ext_irq, >=2
//  EXT_EDGE     0  0: external intr is level (follows synced pin); 1: rising edge sets sticky pending
//  TICK_DIV     1  mtime increments once every TICK_DIV clk cycles, >=1
// PORTS
//  clk           in   1   core clock
//  rst_n         in   1   asynchronous active-low reset
//  i_ext_irq     in   1   external interrupt pin, asynchronous to clk
//  i_ext_ack     in   1   1-cycle pulse from trap entry; clears edge-pending (EXT_EDGE=1 only)
//  i_bus_we      in   1   register write strobe, single cycle
//  i_bus_re      in   1   register read strobe, single cycle
//  i_bus_addr    in   5   byte address; [4:2] selects register, [1:0] ignored
//  i_bus_wdata   in   32  write data
//  o_bus_rdata   out  32  read data, valid the cycle after i_bus_re
//  o_ext_intr    out  1   to CSR i_ext_intr
//  o_sw_intr     out  1   to CSR i_sw_intr (= MSIP bit)
//  o_timer_intr  out  1   machine timer interrupt, (mtime >= mtimecmp)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - Synchroniser flops, prescaler, mtime, MSIP, ext pending, o_bus_rdata and all intr outputs go to 0.
//   - mtimecmp resets to 64'hFFFF_FFFF_FFFF_FFFF, so there is no timer interrupt out of reset.
//   - Reset mid-operation discards everything; no partial state is retained.
//  Register map (index = i_bus_addr[4:2]):
//   0 MSIP        bit0 RW; other bits read 0
//   1 MTIME_LO    RW
//   2 MTIME_HI    RW
//   3 MTIMECMP_LO RW
//   4 MTIMECMP_HI RW
//   5 EXT_STATUS  bit0 = pending/level, bit1 = synced pin (RO); writing bit0=1 clears pending (W1C)
//   6,7           read 0, writes ignored
//  Read path: on an edge with i_bus_re=1, o_bus_rdata <= selected register (pre-write value if i_bus_we is also 1).
//   o_bus_rdata holds its value when i_bus_re=0.
//  Timer:
//   - Prescaler counts 0..TICK_DIV-1; tick on the terminal count (TICK_DIV=1: tick every cycle).
//   - On tick, mtime <= mtime+1 across all 64 bits (LO overflow carries into HI); 64'hFFFF..FF wraps to 0.
//   - A bus write to MTIME_LO/HI wins over the tick in that cycle. The written half takes wdata, the
//     other half keeps its old value, and no carry is applied.
//   - o_timer_intr <= (mtime >= mtimecmp), unsigned, computed from current register values: 1-cycle
//     latency after any change. Writing mtimecmp above mtime drops the interrupt on the next edge.
//  External:
//   - i_ext_irq passes through SYNC_STAGES flops; "synced" is the last stage.
//   - EXT_EDGE=0: o_ext_intr <= synced. W1C and i_ext_ack have no effect.
//   - EXT_EDGE=1: pending sets on synced 0->1 (edge detect uses a delayed copy of synced).
//     It clears on i_ext_ack or an EXT_STATUS W1C. Set and clear in the same cycle: set wins.
//     o_ext_intr <= pending.
//   - Pin-to-output latency: SYNC_STAGES+1 edges (level mode).
//  Software: o_sw_intr <= new MSIP bit0; it follows the write with 1-cycle latency.
//  i_bus_we and i_bus_re are independent; the timer runs regardless of pipeline stalls.
// TESTING
//  - Reset, then read idx 3/4 -> 0xFFFFFFFF/0xFFFFFFFF; all intr outputs 0; after 10 cycles read MTIME_LO -> 10 (TICK_DIV=1).
//  - Write MTIME_LO=0xFFFFFFFF, MTIME_HI=0 -> two ticks later read HI=1, LO=1. Write MTIMECMP_HI=1 and
//    MTIMECMP_LO=5 -> o_timer_intr rises exactly 1 cycle after mtime reaches 0x1_00000005.
//  - Write MSIP=1 -> o_sw_intr=1 the next cycle; write MSIP=0 -> o_sw_intr=0 the next cycle.
//  - EXT_EDGE=1: pulse i_ext_irq high for 5 cycles -> o_ext_intr=1 after 3 edges and stays 1 after the pin
//    drops; i_ext_ack -> 0; pin low -> no re-assert.
//  - EXT_EDGE=1: rising edge of synced in the same cycle as W1C of EXT_STATUS=1 -> pending stays 1.
//  - Assert rst_n=0 mid-count (mtime=0x1234, MSIP=1, timer intr active) -> all outputs 0 immediately and mtime=0.

Source files
------------

// File: rtl/intr_ctrl_if.sv
// Register bus between the core's load/store unit and the interrupt source block.
// The master issues single-cycle read/write strobes; read data returns one cycle later.
interface intr_ctrl_if;
  logic        we;
  logic        re;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output we, output re, output addr, output wdata, input rdata);
  modport slave  (input we, input re, input addr, input wdata, output rdata);
endinterface

// File: rtl/intr_ctrl.sv
// Machine-level interrupt sources: synchronised external pin, MSIP software bit and a
// 64-bit mtime/mtimecmp timer, all presented as registered level outputs.
module intr_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int EXT_EDGE    = 0,
  parameter int TICK_DIV    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ext_irq,
  input  logic        i_ext_ack,
  intr_ctrl_if.slave  bus,
  output logic        o_ext_intr,
  output logic        o_sw_intr,
  output logic        o_timer_intr
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] IDX_MSIP   = 3'd0;
  localparam logic [2:0] IDX_MT_LO  = 3'd1;
  localparam logic [2:0] IDX_MT_HI  = 3'd2;
  localparam logic [2:0] IDX_CMP_LO = 3'd3;
  localparam logic [2:0] IDX_CMP_HI = 3'd4;
  localparam logic [2:0] IDX_EXT    = 3'd5;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   synced_dly_q, synced_dly_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [63:0]            mtime_q, mtime_d;
  logic [63:0]            mtimecmp_q, mtimecmp_d;
  logic                   msip_q, msip_d;
  logic                   pend_q, pend_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   ext_intr_q, ext_intr_d;
  logic                   sw_intr_q, sw_intr_d;
  logic                   timer_intr_q, timer_intr_d;

  logic [2:0]  idx;
  logic        synced;
  logic        tick;
  logic        rise;
  logic        clr;
  logic [31:0] rd_mux;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^bus.addr[1:0];

  always_comb begin
    idx    = bus.addr[4:2];
    synced = sync_q[SYNC_STAGES-1];
    sync_d = {sync_q[SYNC_STAGES-2:0], i_ext_irq};
    synced_dly_d = synced;

    tick    = (presc_q == PW'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);

    // A bus write to either mtime half replaces that half and suppresses the tick entirely.
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (bus.we && idx == IDX_MT_LO) mtime_d = {mtime_q[63:32], bus.wdata};
    if (bus.we && idx == IDX_MT_HI) mtime_d = {bus.wdata, mtime_q[31:0]};

    mtimecmp_d = mtimecmp_q;
    if (bus.we && idx == IDX_CMP_LO) mtimecmp_d = {mtimecmp_q[63:32], bus.wdata};
    if (bus.we && idx == IDX_CMP_HI) mtimecmp_d = {bus.wdata, mtimecmp_q[31:0]};

    msip_d = msip_q;
    if (bus.we && idx == IDX_MSIP) msip_d = bus.wdata[0];

    // Edge mode: a new rising edge beats any clear arriving in the same cycle.
    rise = synced & ~synced_dly_q;
    clr  = i_ext_ack | (bus.we && idx == IDX_EXT && bus.wdata[0]);
    if (EXT_EDGE != 0) pend_d = rise | (pend_q & ~clr);
    else               pend_d = 1'b0;

    ext_intr_d   = (EXT_EDGE != 0) ? pend_d : synced;
    sw_intr_d    = msip_d;
    timer_intr_d = (mtime_q >= mtimecmp_q);

    case (idx)
      IDX_MSIP:   rd_mux = {31'd0, msip_q};
      IDX_MT_LO:  rd_mux = mtime_q[31:0];
      IDX_MT_HI:  rd_mux = mtime_q[63:32];
      IDX_CMP_LO: rd_mux = mtimecmp_q[31:0];
      IDX_CMP_HI: rd_mux = mtimecmp_q[63:32];
      IDX_EXT:    rd_mux = {30'd0, synced, ((EXT_EDGE != 0) ? pend_q : synced)};
      default:    rd_mux = 32'd0;
    endcase
    rdata_d = bus.re ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      synced_dly_q <= 1'b0;
      presc_q      <= '0;
      mtime_q      <= 64'd0;
      mtimecmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q       <= 1'b0;
      pend_q       <= 1'b0;
      rdata_q      <= 32'd0;
      ext_intr_q   <= 1'b0;
      sw_intr_q    <= 1'b0;
      timer_intr_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      synced_dly_q <= synced_dly_d;
      presc_q      <= presc_d;
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      msip_q       <= msip_d;
      pend_q       <= pend_d;
      rdata_q      <= rdata_d;
      ext_intr_q   <= ext_intr_d;
      sw_intr_q    <= sw_intr_d;
      timer_intr_q <= timer_intr_d;
    end
  end

  assign bus.rdata    = rdata_q;
  assign o_ext_intr   = ext_intr_q;
  assign o_sw_intr    = sw_intr_q;
  assign o_timer_intr = timer_intr_q;

endmodule
